// File: rtl/fetch_decode_stage_pkg.sv
// Shared front-end constants: NOP encoding, instruction field offsets, default widths.
// Used by fetch/decode, stall logic and decode.
package fetch_decode_stage_pkg;
    localparam int ADDR_W_DEF = 12;
    localparam int INSN_W_DEF = 32;
    localparam logic [31:0] NOP_INSN = 32'h0;
    localparam int OP_HI = 31;
    localparam int OP_LO = 27;
    localparam int RD_HI = 26;
    localparam int RD_LO = 22;
    localparam int RS_HI = 21;
    localparam int RS_LO = 17;
    localparam int RT_HI = 16;
    localparam int RT_LO = 12;
endpackage

// File: rtl/fetch_decode_stage_fd_latch.sv
// F/D pipeline latch: instruction, link PC and valid bit with hold-enable and flush-clear.
// Clear wins over enable so a redirect always kills the decode slot.
module fd_latch
    import fetch_decode_stage_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int INSN_W = INSN_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic [INSN_W-1:0] i_insn,
    input  logic [ADDR_W-1:0] i_pc,
    output logic [INSN_W-1:0] o_insn,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_valid
);
    logic [INSN_W-1:0] r_insn;
    logic [ADDR_W-1:0] r_pc;
    logic              r_valid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_insn  <= INSN_W'(NOP_INSN);
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (i_clr) begin
            r_insn  <= INSN_W'(NOP_INSN);
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_insn  <= i_insn;
            r_pc    <= i_pc;
            r_valid <= 1'b1;
        end
    end

    assign o_insn  = r_insn;
    assign o_pc    = r_pc;
    assign o_valid = r_valid;
endmodule

// File: rtl/fetch_decode_stage.sv
// Fetch stage + F/D latch: PC, next-PC mux, load-use bubble request, branch flush.
// Optional saturating stall/flush counters when STALL_STATS_EN is defined.
module fetch_decode_stage
    import fetch_decode_stage_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int INSN_W = INSN_W_DEF,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              hazard,
    input  logic              ext_stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [INSN_W-1:0] imem_q,
    output logic [ADDR_W-1:0] pc_f,
    output logic [4:0]        opcode_f,
    output logic [INSN_W-1:0] fd_insn,
    output logic [ADDR_W-1:0] fd_pc,
    output logic              fd_valid,
    output logic [4:0]        fd_rs,
    output logic [4:0]        fd_rt,
    output logic [4:0]        fd_rd,
    output logic              dx_bubble,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_inc;
    logic              w_stall;

    assign w_stall  = hazard | ext_stall;
    assign w_pc_inc = r_pc + ADDR_W'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc <= '0;
        end else if (branch_taken) begin
            r_pc <= branch_target;
        end else if (!w_stall) begin
            r_pc <= w_pc_inc;
        end
    end

    fd_latch #(
        .ADDR_W (ADDR_W),
        .INSN_W (INSN_W)
    ) u_fd_latch (
        .clock   (clock),
        .reset_n (reset_n),
        .i_en    (~w_stall),
        .i_clr   (branch_taken),
        .i_insn  (imem_q),
        .i_pc    (w_pc_inc),
        .o_insn  (fd_insn),
        .o_pc    (fd_pc),
        .o_valid (fd_valid)
    );

    assign pc_f     = r_pc;
    assign opcode_f = imem_q[OP_HI:OP_LO];
    assign fd_rs    = fd_insn[RS_HI:RS_LO];
    assign fd_rt    = fd_insn[RT_HI:RT_LO];
    assign fd_rd    = fd_insn[RD_HI:RD_LO];

    // ext_stall freezes D/X too, and a flush already kills the decode instruction.
    assign dx_bubble = hazard & ~branch_taken & ~ext_stall;

`ifdef STALL_STATS_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && !branch_taken) r_stall_cnt <= sat_inc(r_stall_cnt);
            if (branch_taken)             r_flush_cnt <= sat_inc(r_flush_cnt);
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif
endmodule
